// File: rtl/clkdiv_pkg.sv
// clkdiv_pkg: shared constants, pending-slot type and Hz-to-divisor helper
// for the multi-channel clock divider.
package clkdiv_pkg;

  localparam longint unsigned CLK_FREQ_DEF = 64'd12_000_000;
  localparam int              CNT_W_DEF    = 32;
  localparam int              MIN_DIV      = 2;

  // One queued period reload per channel; high is the
  // already-resolved high time for that period.
  typedef struct packed {
    logic                 valid;
    logic [CNT_W_DEF-1:0] period;
    logic [CNT_W_DEF-1:0] high;
  } pend_t;

  function automatic longint unsigned hz_to_div(
    input longint unsigned freq,
    input longint unsigned clk_hz = CLK_FREQ_DEF
  );
    if (freq == 0) return 64'd0;
    return clk_hz / freq;
  endfunction

endpackage

// File: rtl/clkdiv_multi_hz_if.sv
// clkdiv_multi_hz_if: period-load valid/ready bus (cfg_valid, cfg_ready,
// cfg_chan, cfg_div, plus cfg_high when CLKDIV_DUTY_CTRL_EN is defined).
interface clkdiv_multi_hz_if #(
  parameter int CH_W  = 2,
  parameter int CNT_W = 32
);

  logic             cfg_valid;
  logic             cfg_ready;
  logic [CH_W-1:0]  cfg_chan;
  logic [CNT_W-1:0] cfg_div;
`ifdef CLKDIV_DUTY_CTRL_EN
  logic [CNT_W-1:0] cfg_high;

  modport master (
    output cfg_valid, cfg_chan,
    output cfg_div, cfg_high,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid, cfg_chan,
    input  cfg_div, cfg_high,
    output cfg_ready
  );
`else
  modport master (
    output cfg_valid, cfg_chan, cfg_div,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid, cfg_chan, cfg_div,
    output cfg_ready
  );
`endif

endinterface

// File: rtl/clkdiv_channel.sv
// clkdiv_channel: one divider channel (counter, period/high regs, pending
// slot, registered divided clock and wrap strobe).
// Ports: clk, rst, en, sync, ld_valid/ld_div[/ld_high] load, slot_full,
// div_clk, div_pulse. ld_high exists only with CLKDIV_DUTY_CTRL_EN.
module clkdiv_channel
  import clkdiv_pkg::*;
#(
  parameter int               CNT_W   = CNT_W_DEF,
  parameter logic [CNT_W-1:0] RST_DIV = CNT_W'(4)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             sync,
  input  logic             ld_valid,
  input  logic [CNT_W-1:0] ld_div,
`ifdef CLKDIV_DUTY_CTRL_EN
  input  logic [CNT_W-1:0] ld_high,
`endif
  output logic             slot_full,
  output logic             div_clk,
  output logic             div_pulse
);

  localparam int PW = CNT_W_DEF;
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] MIN_P = CNT_W'(MIN_DIV);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] per_q, per_d;
  logic [CNT_W-1:0] high_q, high_d;
  pend_t            pend_q, pend_d;
  logic             clk_q, clk_d;
  logic             pulse_q, pulse_d;

  logic [CNT_W-1:0] ld_per;
  logic [CNT_W-1:0] ld_hi;
  logic             last;
  logic             wrap;

  always_comb begin
    ld_per = ld_div;
    if (ld_div < MIN_P) ld_per = MIN_P;
  end

`ifdef CLKDIV_DUTY_CTRL_EN
  always_comb begin
    ld_hi = ld_high;
    if (ld_high < ONE) ld_hi = ONE;
    else if (ld_high > ld_per - ONE) ld_hi = ld_per - ONE;
  end
`else
  always_comb ld_hi = ld_per >> 1;
`endif

  always_comb begin
    cnt_d   = cnt_q;
    per_d   = per_q;
    high_d  = high_q;
    pend_d  = pend_q;
    clk_d   = clk_q;
    pulse_d = 1'b0;
    last    = (cnt_q == per_q - ONE);
    wrap    = en && !sync && last;

    // Pending period takes over only at a wrap or sync,
    // so the count restarts at 0 under the new period.
    if (pend_q.valid && (sync || wrap)) begin
      per_d        = pend_q.period[CNT_W-1:0];
      high_d       = pend_q.high[CNT_W-1:0];
      pend_d.valid = 1'b0;
    end

    if (sync) begin
      cnt_d = '0;
      clk_d = 1'b1;
    end else if (en) begin
      cnt_d   = last ? '0 : cnt_q + ONE;
      clk_d   = (cnt_d < high_d);
      pulse_d = wrap;
    end

    // Stored after the apply, so a load coinciding with a
    // wrap or sync waits for the next one.
    if (ld_valid && !pend_q.valid) begin
      pend_d.valid  = 1'b1;
      pend_d.period = PW'(ld_per);
      pend_d.high   = PW'(ld_hi);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      per_q   <= RST_DIV;
      high_q  <= RST_DIV >> 1;
      pend_q  <= '0;
      clk_q   <= 1'b1;
      pulse_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      per_q   <= per_d;
      high_q  <= high_d;
      pend_q  <= pend_d;
      clk_q   <= clk_d;
      pulse_q <= pulse_d;
    end
  end

  assign slot_full = pend_q.valid;
  assign div_clk   = clk_q;
  assign div_pulse = pulse_q;

endmodule

// File: rtl/clkdiv_multi_hz.sv
// clkdiv_multi_hz: CHANNELS programmable dividers with runtime period
// reload over cfg (valid/ready), global sync, per-channel enable.
// Ports: clk, rst, enable, sync, cfg (slave), divided_clk, divided_pulse.
// Macro CLKDIV_DUTY_CTRL_EN adds cfg_high for programmable high time.
module clkdiv_multi_hz
  import clkdiv_pkg::*;
#(
  parameter longint unsigned CLK_FREQ   = CLK_FREQ_DEF,
  parameter int              CHANNELS   = 4,
  parameter int              CNT_W      = CNT_W_DEF,
  parameter longint unsigned DEFAULT_HZ = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] enable,
  input  logic                sync,
  clkdiv_multi_hz_if.slave    cfg,
  output logic [CHANNELS-1:0] divided_clk,
  output logic [CHANNELS-1:0] divided_pulse
);

  localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int NSLOT = 2 ** CH_W;
  localparam longint unsigned P0 = hz_to_div(DEFAULT_HZ, CLK_FREQ);
  localparam logic [CNT_W-1:0] RST_DIV = CNT_W'(P0);

  if (P0 < MIN_DIV || P0 >= (64'd1 << CNT_W)) begin : g_p0_bad
    $error("clkdiv_multi_hz: reset period out of range");
  end

  if (CNT_W > CNT_W_DEF) begin : g_w_bad
    $error("clkdiv_multi_hz: CNT_W wider than pending slot");
  end

  logic [CHANNELS-1:0] full;
  logic [NSLOT-1:0]    full_pad;
  logic                xfer;

  // Unused channel codes read as an always-free slot, so
  // loads to them complete and are dropped.
  always_comb begin
    full_pad = '0;
    full_pad[CHANNELS-1:0] = full;
  end

  assign cfg.cfg_ready = ~full_pad[cfg.cfg_chan];
  assign xfer = cfg.cfg_valid & cfg.cfg_ready;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    localparam logic [CH_W-1:0] IDX = CH_W'(i);

    logic ld;
    assign ld = xfer && (cfg.cfg_chan == IDX);

    clkdiv_channel #(
      .CNT_W   (CNT_W),
      .RST_DIV (RST_DIV)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .en        (enable[i]),
      .sync      (sync),
      .ld_valid  (ld),
      .ld_div    (cfg.cfg_div),
`ifdef CLKDIV_DUTY_CTRL_EN
      .ld_high   (cfg.cfg_high),
`endif
      .slot_full (full[i]),
      .div_clk   (divided_clk[i]),
      .div_pulse (divided_pulse[i])
    );
  end

endmodule

// File: tb/tb_clkdiv_multi_hz.sv
// tb_clkdiv_multi_hz: directed bench for clkdiv_multi_hz with
// CLK_FREQ=12, DEFAULT_HZ=3 (P0=4), CHANNELS=4.
module tb_clkdiv_multi_hz;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] enable;
  logic       sync;
  logic [3:0] divided_clk;
  logic [3:0] divided_pulse;

  int n_chk = 0;
  int n_fail = 0;

  int k;
  int nop_k;
  int org_m [4];
  int per_m [4];
  int h_m   [4];
  logic [3:0] en_m;

  clkdiv_multi_hz_if #(.CH_W(2), .CNT_W(32)) cfg_if ();

  clkdiv_multi_hz #(
    .CLK_FREQ   (64'd12),
    .CHANNELS   (4),
    .CNT_W      (32),
    .DEFAULT_HZ (64'd3)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .enable        (enable),
    .sync          (sync),
    .cfg           (cfg_if),
    .divided_clk   (divided_clk),
    .divided_pulse (divided_pulse)
  );

  always #5 clk = ~clk;

  task automatic check(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] exp_clk();
    logic [3:0] r;
    for (int i = 0; i < 4; i++) begin
      r[i] = (((k - org_m[i]) % per_m[i]) < h_m[i]);
    end
    return r;
  endfunction

  function automatic logic [3:0] exp_pulse();
    logic [3:0] r;
    for (int i = 0; i < 4; i++) begin
      r[i] = (((k - org_m[i]) % per_m[i]) == 0)
             && (k != nop_k) && en_m[i];
    end
    return r;
  endfunction

  task automatic model_reset();
    k = 0;
    nop_k = 0;
    en_m = 4'h0;
    for (int i = 0; i < 4; i++) begin
      org_m[i] = 0;
      per_m[i] = 4;
      h_m[i] = 2;
    end
  endtask

  task automatic tick();
    logic [3:0] en_s;
    logic       s_s;
    en_s = enable;
    s_s = sync;
    @(negedge clk);
    k++;
    en_m = s_s ? 4'h0 : en_s;
    for (int i = 0; i < 4; i++) begin
      if (!en_s[i]) org_m[i]++;
    end
    if (s_s) begin
      for (int i = 0; i < 4; i++) org_m[i] = k;
      nop_k = k;
    end
  endtask

  task automatic check_all();
    check($sformatf("clk k=%0d", k), 64'(divided_clk), 64'(exp_clk()));
    check($sformatf("pulse k=%0d", k), 64'(divided_pulse), 64'(exp_pulse()));
  endtask

  task automatic load(input int ch, input int div, input int hi);
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_chan = 2'(ch);
    cfg_if.cfg_div = 32'(div);
`ifdef CLKDIV_DUTY_CTRL_EN
    cfg_if.cfg_high = 32'(hi);
`else
    if (hi != 0) $display("note: cfg_high %0d ignored", hi);
`endif
  endtask

  initial begin
    rst = 1'b1;
    enable = 4'h0;
    sync = 1'b0;
    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_chan = 2'd0;
    cfg_if.cfg_div = 32'd0;
`ifdef CLKDIV_DUTY_CTRL_EN
    cfg_if.cfg_high = 32'd0;
`endif
    repeat (2) @(negedge clk);
    check("rst_clk", 64'(divided_clk), 64'hF);
    check("rst_pulse", 64'(divided_pulse), 64'h0);
    check("rst_ready", 64'(cfg_if.cfg_ready), 64'h1);

    rst = 1'b0;
    enable = 4'hF;
    model_reset();
    repeat (12) begin
      tick();
      check_all();
    end

    // ch1 at cnt=1: load period 5
    tick();
    check_all();
    load(1, 5, 0);
    #1 check("ready_free", 64'(cfg_if.cfg_ready), 64'h1);
    tick();
    check_all();
    cfg_if.cfg_div = 32'd7;
    check("ready_full1", 64'(cfg_if.cfg_ready), 64'h0);
    tick();
    check_all();
    check("ready_full2", 64'(cfg_if.cfg_ready), 64'h0);
    cfg_if.cfg_valid = 1'b0;
    tick();
    per_m[1] = 5;
    org_m[1] = 16;
    check_all();
    check("ready_wrap", 64'(cfg_if.cfg_ready), 64'h1);
    repeat (10) begin
      tick();
      check_all();
    end

    // ch2: divisors 0 then 1 both clamp to 2
    load(2, 0, 0);
    tick();
    check_all();
    check("ready_ch2", 64'(cfg_if.cfg_ready), 64'h0);
    cfg_if.cfg_valid = 1'b0;
    tick();
    per_m[2] = 2;
    h_m[2] = 1;
    org_m[2] = 28;
    check_all();
    load(2, 1, 0);
    #1 check("ready_ch2b", 64'(cfg_if.cfg_ready), 64'h1);
    tick();
    check_all();
    cfg_if.cfg_valid = 1'b0;
    repeat (5) begin
      tick();
      check_all();
    end

    // stagger ch0, load ch3 on its wrap, then sync
    enable = 4'hE;
    tick();
    check_all();
    enable = 4'hF;
    load(3, 6, 0);
    tick();
    check_all();
    check("ready_ch3", 64'(cfg_if.cfg_ready), 64'h0);
    load(0, 3, 0);
    sync = 1'b1;
    #1 check("ready_ch0", 64'(cfg_if.cfg_ready), 64'h1);
    tick();
    per_m[3] = 6;
    h_m[3] = 3;
    check_all();
    check("sync_clk", 64'(divided_clk), 64'hF);
    sync = 1'b0;
    cfg_if.cfg_valid = 1'b0;
    check("ready_sync", 64'(cfg_if.cfg_ready), 64'h0);
    for (int j = 0; j < 13; j++) begin
      tick();
      if (k == 41) begin
        per_m[0] = 3;
        h_m[0] = 1;
        org_m[0] = 41;
      end
      check_all();
    end

    // freeze ch3 for 3 cycles
    enable = 4'h7;
    repeat (3) begin
      tick();
      check_all();
    end
    enable = 4'hF;
    repeat (7) begin
      tick();
      check_all();
    end

    // async reset between edges drops the pending load
    load(1, 9, 0);
    tick();
    check_all();
    cfg_if.cfg_valid = 1'b0;
    #1 check("ready_pre_rst", 64'(cfg_if.cfg_ready), 64'h0);
    #1 rst = 1'b1;
    #1;
    check("arst_clk", 64'(divided_clk), 64'hF);
    check("arst_pulse", 64'(divided_pulse), 64'h0);
    check("arst_ready", 64'(cfg_if.cfg_ready), 64'h1);
    #1 rst = 1'b0;
    model_reset();
    repeat (10) begin
      tick();
      check_all();
    end

`ifdef CLKDIV_DUTY_CTRL_EN
    load(0, 6, 0);
    tick();
    check_all();
    cfg_if.cfg_valid = 1'b0;
    tick();
    per_m[0] = 6;
    h_m[0] = 1;
    org_m[0] = 12;
    check_all();
    load(0, 6, 9);
    tick();
    check_all();
    cfg_if.cfg_valid = 1'b0;
    for (int j = 0; j < 12; j++) begin
      tick();
      if (k == 18) begin
        h_m[0] = 5;
        org_m[0] = 18;
      end
      check_all();
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
